// File: rtl/bs_fin_dat.sv
// Output finaliser for the barrel-shifter datapath: clamps/rounds a flagged 20-bit word to a
// 16-bit signed sample through a 2-stage valid/ready pipeline, with saturation event tracking.
module bs_fin_dat #(
  parameter int T_0_DAT_WIDTH = 20,
  parameter int I_0_DAT_WIDTH = 16,
  parameter int SAT_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [T_0_DAT_WIDTH-1:0] t_0_dat,
  input  logic                     t_0_valid,
  output logic                     t_0_ready,
  input  logic                     t_cfg_rnd_en,
  input  logic                     t_sat_clr,
  output logic [I_0_DAT_WIDTH-1:0] i_0_dat,
  output logic                     i_0_sat,
  output logic                     i_0_valid,
  input  logic                     i_0_ready,
  output logic [SAT_CNT_WIDTH-1:0] sat_cnt,
  output logic                     sat_sticky
);

  localparam int NEG_BIT  = 19;
  localparam int PSAT_BIT = 18;
  localparam int RND_BIT  = 17;
  localparam int SIGN_BIT = 16;

  localparam logic [I_0_DAT_WIDTH-1:0] POS_MAX = {1'b0, {(I_0_DAT_WIDTH-1){1'b1}}};
  localparam logic [I_0_DAT_WIDTH-1:0] NEG_MIN = {1'b1, {(I_0_DAT_WIDTH-1){1'b0}}};
  localparam logic [SAT_CNT_WIDTH-1:0] CNT_MAX = {SAT_CNT_WIDTH{1'b1}};

  // Stage 1: raw word plus the rounding mode captured with it
  logic                     v1_q;
  logic [T_0_DAT_WIDTH-1:0] word_q;
  logic                     rnd_q;

  // Stage 2: finalised result, drives the output port directly
  logic                     v2_q;
  logic [I_0_DAT_WIDTH-1:0] dat_q, dat_d;
  logic                     sat_q, sat_d;

  logic [SAT_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     sticky_q, sticky_d;

  logic s1_en, s2_en, sat_xfer, rnd_inc;
  logic [I_0_DAT_WIDTH-1:0] shift_data;

  assign s2_en     = !v2_q || i_0_ready;
  assign s1_en     = !v1_q || s2_en;
  assign t_0_ready = !reset && s1_en;

  assign shift_data = word_q[I_0_DAT_WIDTH-1:0];
  assign rnd_inc    = rnd_q && word_q[RND_BIT];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    dat_d = shift_data + I_0_DAT_WIDTH'(rnd_inc);
    sat_d = 1'b0;
    if (word_q[NEG_BIT]) begin
      dat_d = '0;
      sat_d = 1'b1;
    end else if (word_q[PSAT_BIT]) begin
      dat_d = word_q[SIGN_BIT] ? NEG_MIN : POS_MAX;
      sat_d = 1'b1;
    end else if (rnd_inc && shift_data == POS_MAX) begin
      dat_d = POS_MAX;
      sat_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      if (s1_en) v1_q <= t_0_valid;
      if (s2_en) v2_q <= v1_q;
    end
  end

  // NOTE: stage-1 payload is qualified by v1_q, so it needs no reset and stays a plain enable flop.
  always_ff @(posedge clk) begin
    if (s1_en && t_0_valid) begin
      word_q <= t_0_dat;
      rnd_q  <= t_cfg_rnd_en;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dat_q <= '0;
      sat_q <= 1'b0;
    end else if (s2_en && v1_q) begin
      dat_q <= dat_d;
      sat_q <= sat_d;
    end
  end

  assign sat_xfer = v2_q && i_0_ready && sat_q;

  // A clear coinciding with a saturated transfer keeps that one event.
  always_comb begin
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (t_sat_clr) begin
      cnt_d    = sat_xfer ? SAT_CNT_WIDTH'(1) : '0;
      sticky_d = sat_xfer;
    end else if (sat_xfer) begin
      sticky_d = 1'b1;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + SAT_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign i_0_dat    = dat_q;
  assign i_0_sat    = sat_q;
  assign i_0_valid  = v2_q;
  assign sat_cnt    = cnt_q;
  assign sat_sticky = sticky_q;

endmodule

// File: tb/tb_bs_fin_dat.sv
// Self-checking bench for bs_fin_dat: queue-based reference model, directed cases and random traffic.
// A second instance with a 4-bit counter exercises counter saturation in a short run.
module tb_bs_fin_dat;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] t_0_dat = '0;
  logic        t_0_valid = 1'b0;
  logic        t_cfg_rnd_en = 1'b0;
  logic        t_sat_clr = 1'b0;
  logic        i_0_ready = 1'b0;

  logic        t_0_ready, i_0_sat, i_0_valid, sat_sticky;
  logic [15:0] i_0_dat, sat_cnt;
  logic        t_0_ready_s, i_0_sat_s, i_0_valid_s, sat_sticky_s;
  logic [15:0] i_0_dat_s;
  logic [3:0]  sat_cnt_s;

  always #5 clk = ~clk;

  bs_fin_dat dut (
    .clk(clk), .reset(reset), .t_0_dat(t_0_dat), .t_0_valid(t_0_valid), .t_0_ready(t_0_ready),
    .t_cfg_rnd_en(t_cfg_rnd_en), .t_sat_clr(t_sat_clr), .i_0_dat(i_0_dat), .i_0_sat(i_0_sat),
    .i_0_valid(i_0_valid), .i_0_ready(i_0_ready), .sat_cnt(sat_cnt), .sat_sticky(sat_sticky)
  );

  bs_fin_dat #(.SAT_CNT_WIDTH(4)) dut_s (
    .clk(clk), .reset(reset), .t_0_dat(t_0_dat), .t_0_valid(t_0_valid), .t_0_ready(t_0_ready_s),
    .t_cfg_rnd_en(t_cfg_rnd_en), .t_sat_clr(t_sat_clr), .i_0_dat(i_0_dat_s), .i_0_sat(i_0_sat_s),
    .i_0_valid(i_0_valid_s), .i_0_ready(i_0_ready), .sat_cnt(sat_cnt_s), .sat_sticky(sat_sticky_s)
  );

  typedef struct {
    logic [15:0] dat;
    logic        sat;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int unsigned m_cnt = 0, m_cnt_s = 0;
  logic        m_sticky = 1'b0;
  int          n_cmp = 0, n_bad = 0;
  int          n_out = 0, dut_acc = 0;
  logic [15:0] last_dat = '0;
  logic        last_sat = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output value straight from the finalisation rules, highest priority first.
  function automatic exp_t ref_out(input logic [19:0] w, input logic rnd);
    exp_t e;
    logic inc;
    e.acc = 0;
    inc   = rnd && w[17];
    if (w[19]) begin
      e.dat = 16'h0000; e.sat = 1'b1;
    end else if (w[18]) begin
      e.dat = w[16] ? 16'h8000 : 16'h7FFF; e.sat = 1'b1;
    end else if (inc && w[15:0] == 16'h7FFF) begin
      e.dat = 16'h7FFF; e.sat = 1'b1;
    end else begin
      e.dat = 16'((32'(w[15:0]) + (inc ? 32'd1 : 32'd0)) % 65536); e.sat = 1'b0;
    end
    return e;
  endfunction

  // A word is visible two edges after the edge that accepted it.
  function automatic logic model_valid();
    return q.size() > 0 && (cyc - q[0].acc) >= 2;
  endfunction

  task automatic check_state();
    logic mv;
    mv = model_valid();
    check("i_0_valid", i_0_valid, mv);
    check("i_0_valid_s", i_0_valid_s, mv);
    if (mv) begin
      check("i_0_dat", i_0_dat, q[0].dat);
      check("i_0_sat", i_0_sat, q[0].sat);
    end
    check("sat_cnt", sat_cnt, m_cnt);
    check("sat_cnt_s", sat_cnt_s, m_cnt_s);
    check("sat_sticky", sat_sticky, m_sticky);
    check("sat_sticky_s", sat_sticky_s, m_sticky);
  endtask

  task automatic step(input logic v, input logic [19:0] d, input logic rnd,
                      input logic rdy, input logic clr);
    logic mv, mr, in_x, out_x, sat_x;
    exp_t e;
    @(negedge clk);
    check_state();
    mv = model_valid();
    t_0_valid = v; t_0_dat = d; t_cfg_rnd_en = rnd; i_0_ready = rdy; t_sat_clr = clr;
    #1;
    mr = (q.size() < 2) || rdy;
    check("t_0_ready", t_0_ready, mr);
    in_x  = v && mr;
    out_x = mv && rdy;
    if (v && t_0_ready) dut_acc++;
    if (out_x) begin
      last_dat = i_0_dat; last_sat = i_0_sat; n_out++;
    end
    @(posedge clk);
    sat_x = 1'b0;
    if (out_x) begin
      sat_x = q[0].sat;
      void'(q.pop_front());
    end
    if (clr) begin
      m_cnt = sat_x ? 1 : 0; m_cnt_s = sat_x ? 1 : 0; m_sticky = sat_x;
    end else if (sat_x) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt_s < 15) m_cnt_s++;
      m_sticky = 1'b1;
    end
    if (in_x) begin
      e = ref_out(d, rnd);
      e.acc = cyc;
      q.push_back(e);
    end
    cyc++;
  endtask

  // Sends one word and drains it, bounding the wait for the output.
  task automatic xfer(input string name, input logic [19:0] w, input logic rnd,
                      input logic [15:0] exp_dat, input logic exp_sat);
    int n0;
    n0 = n_out;
    step(1'b1, w, rnd, 1'b1, 1'b0);
    for (int i = 0; i < 4 && n_out == n0; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check({name, "_count"}, n_out - n0, 1);
    check({name, "_dat"}, last_dat, exp_dat);
    check({name, "_sat"}, last_sat, exp_sat);
  endtask

  task automatic apply_reset_midcycle();
    #2 reset = 1'b1;
    #1;
    check("rst_async_valid", i_0_valid, 1'b0);
    check("rst_ready", t_0_ready, 1'b0);
    check("rst_cnt", sat_cnt, 16'h0);
    check("rst_dat", i_0_dat, 16'h0);
    q.delete();
    m_cnt = 0; m_cnt_s = 0; m_sticky = 1'b0;
    t_0_valid = 1'b0; t_sat_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n0;
    logic [19:0] w;

    #1;
    check("reset_valid", i_0_valid, 1'b0);
    check("reset_dat", i_0_dat, 16'h0);
    check("reset_sat", i_0_sat, 1'b0);
    check("reset_cnt", sat_cnt, 16'h0);
    check("reset_sticky", sat_sticky, 1'b0);
    check("reset_ready", t_0_ready, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Sustained stream at full rate
    n0 = n_out;
    repeat (8) step(1'b1, 20'h0_1234, 1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("stream_count", n_out - n0, 8);
    check("stream_dat", last_dat, 16'h1234);

    // Rounding and rounding overflow
    xfer("rnd_up", 20'h2_8000, 1'b1, 16'h8001, 1'b0);
    xfer("rnd_off", 20'h2_8000, 1'b0, 16'h8000, 1'b0);
    xfer("rnd_ovf", 20'h2_7FFF, 1'b1, 16'h7FFF, 1'b1);
    #1 check("rnd_ovf_cnt", sat_cnt, 16'h1);
    xfer("rnd_wrap", 20'h2_FFFF, 1'b1, 16'h0000, 1'b0);

    // Clamp cases
    xfer("psat_neg", 20'h5_0000, 1'b0, 16'h8000, 1'b1);
    xfer("psat_pos", 20'h4_0000, 1'b0, 16'h7FFF, 1'b1);
    xfer("neg_flag", 20'hC_0000, 1'b1, 16'h0000, 1'b1);

    // Full stall: only two words fit
    dut_acc = 0;
    n0 = n_out;
    for (int i = 0; i < 5; i++) step(1'b1, 20'h0_0100 + 20'(i), 1'b0, 1'b0, 1'b0);
    check("stall_accepted", dut_acc, 2);
    check("stall_hold_dat", i_0_dat, 16'h0100);
    repeat (4) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("stall_drained", n_out - n0, 2);
    check("stall_last", last_dat, 16'h0101);

    // Counter saturation on the 4-bit instance, then clear racing a saturated transfer
    for (int i = 0; i < 10; i++) xfer("sat_fill", 20'h4_0000, 1'b0, 16'h7FFF, 1'b1);
    #1 check("cnt_s_near_max", sat_cnt_s, 4'hE);
    for (int i = 0; i < 3; i++) xfer("sat_top", 20'h4_0000, 1'b0, 16'h7FFF, 1'b1);
    #1 check("cnt_s_pinned", sat_cnt_s, 4'hF);
    check("cnt_wide", sat_cnt, 16'd17);
    step(1'b1, 20'h4_0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    #1 check("clr_collide_cnt", sat_cnt, 16'h1);
    check("clr_collide_sticky", sat_sticky, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    #1 check("clr_alone_cnt", sat_cnt, 16'h0);
    check("clr_alone_sticky", sat_sticky, 1'b0);

    // Reset with two words in flight
    step(1'b1, 20'h4_0055, 1'b0, 1'b0, 1'b0);
    step(1'b1, 20'h0_0066, 1'b0, 1'b0, 1'b0);
    n0 = n_out;
    apply_reset_midcycle();
    repeat (5) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("post_reset_outputs", n_out - n0, 0);
    check("post_reset_cnt", sat_cnt, 16'h0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      w = 20'($urandom);
      w[19] = ($urandom_range(7) == 0);
      w[18] = ($urandom_range(7) == 0);
      case ($urandom_range(3))
        0: w[15:0] = 16'h7FFF;
        1: w[15:0] = 16'hFFFF;
        default: ;
      endcase
      step($urandom_range(9) < 7, w, 1'($urandom), $urandom_range(9) < 7,
           $urandom_range(39) == 0);
    end
    repeat (4) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("final_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
